// File: rtl/renee_bump_sequencer_if.sv
// Bumper, sensor and wheel-action bundle for the Renee bump sequencer.
// The master drives bumpers and sensor actions; the slave drives wheel outputs.
interface renee_bump_sequencer_if;
    logic       lb;
    logic       rb;
    logic       fb;
    logic       bb;
    logic [2:0] lwa_in;
    logic [2:0] rwa_in;
    logic [2:0] lwa;
    logic [2:0] rwa;
    logic       busy;
    logic [2:0] state;

    modport master (
        output lb, rb, fb, bb, lwa_in, rwa_in,
        input  lwa, rwa, busy, state
    );

    modport slave (
        input  lb, rb, fb, bb, lwa_in, rwa_in,
        output lwa, rwa, busy, state
    );
endinterface

// File: rtl/renee_bump_sequencer.sv
// Timed bump-recovery sequencer: brake, escape and pivot after a bumper hit.
// Optional macro RENEE_SEQ_RETRY_LIMIT_EN adds a retry limit and FAULT state.
module renee_bump_sequencer #(
    parameter int TICK_DIV    = 5000000,
    parameter int BRAKE_TICKS = 1,
    parameter int ESC_TICKS   = 10,
    parameter int TURN_TICKS  = 5,
    parameter int MAX_RETRY   = 3
) (
    input logic clk,
    input logic rst,
    renee_bump_sequencer_if.slave bus
);
    localparam logic [2:0] S_DRIVE   = 3'b000;
    localparam logic [2:0] S_BRAKE   = 3'b001;
    localparam logic [2:0] S_REVERSE = 3'b010;
    localparam logic [2:0] S_FORWARD = 3'b011;
    localparam logic [2:0] S_TURN    = 3'b100;
    localparam logic [2:0] S_HOLD    = 3'b101;
`ifdef RENEE_SEQ_RETRY_LIMIT_EN
    localparam logic [2:0] S_FAULT   = 3'b110;
    localparam int W_R = $clog2(MAX_RETRY + 1);
`endif

    localparam logic [2:0] A_REV  = 3'b100;
    localparam logic [2:0] A_FWD  = 3'b010;
    localparam logic [2:0] A_STOP = 3'b001;

    localparam int MAX_BE = (BRAKE_TICKS > ESC_TICKS) ? BRAKE_TICKS : ESC_TICKS;
    localparam int MAX_T  = (MAX_BE > TURN_TICKS) ? MAX_BE : TURN_TICKS;
    localparam int W_T    = $clog2(MAX_T + 1);
    localparam int W_P    = $clog2(TICK_DIV);

    logic [2:0]     r_state;
    logic [2:0]     w_next;
    logic [3:0]     r_bump_q;
    logic           r_hit_f;
    logic           r_hit_b;
    logic           r_turn_dir;
    logic [W_P-1:0] r_pre;
    logic [W_T-1:0] r_tick;
    logic [W_T-1:0] w_last;
    logic           w_tick_end;
    logic           w_done;
    logic           w_any;
    logic           w_enter_brake;
    logic [2:0]     r_lwa;
    logic [2:0]     r_rwa;
`ifdef RENEE_SEQ_RETRY_LIMIT_EN
    logic [W_R-1:0] r_retry;
`endif

    // bump_q bits: [3]=left, [2]=right, [1]=front, [0]=back, active-high
    assign w_any         = |r_bump_q;
    assign w_tick_end    = (r_pre == W_P'(TICK_DIV - 1));
    assign w_done        = w_tick_end && (r_tick == w_last);
    assign w_enter_brake = (w_next == S_BRAKE) && (r_state != S_BRAKE);

    assign bus.lwa   = r_lwa;
    assign bus.rwa   = r_rwa;
    assign bus.state = r_state;
    assign bus.busy  = (r_state != S_DRIVE);

    // Terminal tick index of the current timed phase
    always_comb begin
        w_last = '0;
        case (r_state)
            S_BRAKE:   w_last = W_T'(BRAKE_TICKS - 1);
            S_REVERSE: w_last = W_T'(ESC_TICKS - 1);
            S_FORWARD: w_last = W_T'(ESC_TICKS - 1);
            S_TURN:    w_last = W_T'(TURN_TICKS - 1);
            default:   w_last = '0;
        endcase
    end

    // Next-state decision, driven only by registered bumpers and phase ends
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_DRIVE:
                if (w_any) w_next = S_BRAKE;
            S_BRAKE:
                if (w_done) begin
                    if (r_hit_f && r_hit_b) w_next = S_HOLD;
                    else if (r_hit_f)       w_next = S_REVERSE;
                    else if (r_hit_b)       w_next = S_FORWARD;
                    else                    w_next = S_TURN;
                end
            S_REVERSE:
                if (w_done) w_next = S_TURN;
            S_FORWARD:
                if (w_done) w_next = S_DRIVE;
            S_TURN:
                if (w_done) begin
`ifdef RENEE_SEQ_RETRY_LIMIT_EN
                    if (!w_any)
                        w_next = S_DRIVE;
                    else if (r_retry == W_R'(MAX_RETRY))
                        w_next = S_FAULT;
                    else
                        w_next = S_BRAKE;
`else
                    w_next = w_any ? S_BRAKE : S_DRIVE;
`endif
                end
            S_HOLD:
                if (!w_any && w_tick_end) w_next = S_DRIVE;
`ifdef RENEE_SEQ_RETRY_LIMIT_EN
            S_FAULT:
                if (!w_any && bus.lwa_in == A_STOP && bus.rwa_in == A_STOP)
                    w_next = S_DRIVE;
`endif
            default: w_next = S_DRIVE;
        endcase
    end

    // State, bumper sync, hit latch and phase timing
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_DRIVE;
            r_bump_q   <= '0;
            r_hit_f    <= 1'b0;
            r_hit_b    <= 1'b0;
            r_turn_dir <= 1'b0;
            r_pre      <= '0;
            r_tick     <= '0;
        end else begin
            r_state  <= w_next;
            r_bump_q <= ~{bus.lb, bus.rb, bus.fb, bus.bb};
            if (w_enter_brake) begin
                r_hit_f    <= r_bump_q[1];
                r_hit_b    <= r_bump_q[0];
                r_turn_dir <= r_bump_q[3] & ~r_bump_q[2];
            end
            if (w_next != r_state || r_state == S_DRIVE ||
                (r_state == S_HOLD && w_any) ||
                !(r_state inside {S_BRAKE, S_REVERSE, S_FORWARD,
                                  S_TURN, S_HOLD})) begin
                r_pre  <= '0;
                r_tick <= '0;
            end else if (w_tick_end) begin
                r_pre <= '0;
                if (r_state != S_HOLD) r_tick <= r_tick + 1'b1;
            end else begin
                r_pre <= r_pre + 1'b1;
            end
        end
    end

`ifdef RENEE_SEQ_RETRY_LIMIT_EN
    // Count consecutive unresolved manoeuvres; a clean DRIVE clears it
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_retry <= '0;
        else if (r_state == S_DRIVE && !w_any)
            r_retry <= '0;
        else if (r_state == S_TURN && w_done && w_any &&
                 r_retry != W_R'(MAX_RETRY))
            r_retry <= r_retry + 1'b1;
    end
`endif

    // Registered wheel actions, one cycle behind the state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_lwa <= A_STOP;
            r_rwa <= A_STOP;
        end else begin
            unique case (r_state)
                S_DRIVE: begin
                    r_lwa <= bus.lwa_in;
                    r_rwa <= bus.rwa_in;
                end
                S_REVERSE: begin
                    r_lwa <= A_REV;
                    r_rwa <= A_REV;
                end
                S_FORWARD: begin
                    r_lwa <= A_FWD;
                    r_rwa <= A_FWD;
                end
                S_TURN: begin
                    r_lwa <= r_turn_dir ? A_FWD : A_REV;
                    r_rwa <= r_turn_dir ? A_REV : A_FWD;
                end
                default: begin
                    r_lwa <= A_STOP;
                    r_rwa <= A_STOP;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_renee_bump_sequencer.sv
// Directed bench for renee_bump_sequencer with short simulation timing.
// Define RENEE_SEQ_RETRY_LIMIT_EN to check the FAULT path as well.
module tb_renee_bump_sequencer;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    renee_bump_sequencer_if bus ();

    renee_bump_sequencer #(
        .TICK_DIV(4), .BRAKE_TICKS(1), .ESC_TICKS(3),
        .TURN_TICKS(2), .MAX_RETRY(3)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: sim time exceeded, got no end, need end");
        $fatal(1);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        bus.lb = 1; bus.rb = 1; bus.fb = 1; bus.bb = 1;
        bus.lwa_in = 3'b010; bus.rwa_in = 3'b001;
        rst = 1;
        step(); step();
        checks++;
        if ({bus.lwa, bus.rwa} !== 6'b001001) begin
            errors++;
            $display("FAIL reset_act got %b need 001001", {bus.lwa, bus.rwa});
        end
        checks++;
        if ({bus.busy, bus.state} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_state got %b need 0000", {bus.busy, bus.state});
        end
        rst = 0;
        step();
    endtask

    task automatic test_passthrough();
        bus.lwa_in = 3'b010; bus.rwa_in = 3'b001;
        step();
        checks++;
        if ({bus.lwa, bus.rwa, bus.busy} !== 7'b0100010) begin
            errors++;
            $display("FAIL pass got %b need 0100010", {bus.lwa, bus.rwa, bus.busy});
        end
        bus.lwa_in = 3'b100; bus.rwa_in = 3'b010;
        step();
        checks++;
        if ({bus.lwa, bus.rwa} !== 6'b100010) begin
            errors++;
            $display("FAIL pass2 got %b need 100010", {bus.lwa, bus.rwa});
        end
        bus.lwa_in = 3'b010; bus.rwa_in = 3'b001;
        step();
    endtask

    // k counts samples after the edge that enters BRAKE
    task automatic test_front_hit();
        logic [2:0] es;
        logic [5:0] ea;
        int         km;
        int         nb = 0;
        bus.fb = 0; step(); bus.fb = 1; step();
        for (int k = 0; k <= 25; k++) begin
            es = k < 4 ? 3'b001 : k < 16 ? 3'b010 : k < 24 ? 3'b100 : 3'b000;
            km = k - 1;
            if (k == 0 || km >= 24) ea = 6'b010001;
            else if (km < 4)        ea = 6'b001001;
            else if (km < 16)       ea = 6'b100100;
            else                    ea = 6'b100010;
            checks++;
            if (bus.state !== es) begin
                errors++;
                $display("FAIL front_state k=%0d got %b need %b", k, bus.state, es);
            end
            checks++;
            if ({bus.lwa, bus.rwa} !== ea) begin
                errors++;
                $display("FAIL front_act k=%0d got %b need %b", k, {bus.lwa, bus.rwa}, ea);
            end
            if (bus.busy) nb++;
            if (k < 25) step();
        end
        checks++;
        if (nb !== 24) begin
            errors++;
            $display("FAIL front_busy got %0d need 24", nb);
        end
        step();
    endtask

    task automatic test_left_hit();
        logic [2:0] es;
        logic [5:0] ea;
        int         km;
        int         nb = 0;
        bus.lb = 0; step(); bus.lb = 1; step();
        for (int k = 0; k <= 13; k++) begin
            es = k < 4 ? 3'b001 : k < 12 ? 3'b100 : 3'b000;
            km = k - 1;
            if (k == 0 || km >= 12) ea = 6'b010001;
            else if (km < 4)        ea = 6'b001001;
            else                    ea = 6'b010100;
            checks++;
            if (bus.state !== es) begin
                errors++;
                $display("FAIL left_state k=%0d got %b need %b", k, bus.state, es);
            end
            checks++;
            if ({bus.lwa, bus.rwa} !== ea) begin
                errors++;
                $display("FAIL left_act k=%0d got %b need %b", k, {bus.lwa, bus.rwa}, ea);
            end
            if (bus.busy) nb++;
            if (k < 13) step();
        end
        checks++;
        if (nb !== 12) begin
            errors++;
            $display("FAIL left_busy got %0d need 12", nb);
        end
        step();
    endtask

    task automatic test_back_hit();
        logic [2:0] es;
        logic [5:0] ea;
        int         km;
        bus.bb = 0; step(); bus.bb = 1; step();
        for (int k = 0; k <= 17; k++) begin
            es = k < 4 ? 3'b001 : k < 16 ? 3'b011 : 3'b000;
            km = k - 1;
            if (k == 0 || km >= 16) ea = 6'b010001;
            else if (km < 4)        ea = 6'b001001;
            else                    ea = 6'b010010;
            checks++;
            if ({bus.state, bus.lwa, bus.rwa} !== {es, ea}) begin
                errors++;
                $display("FAIL back k=%0d got %b need %b", k,
                         {bus.state, bus.lwa, bus.rwa}, {es, ea});
            end
            if (k < 17) step();
        end
        step();
    endtask

    // Release takes one sync cycle plus one full 4-cycle tick
    task automatic test_hold();
        int n = 0;
        bus.fb = 0; bus.bb = 0; step(); step();
        for (int k = 0; k < 12; k++) step();
        checks++;
        if ({bus.state, bus.lwa, bus.rwa} !== 9'b101001001) begin
            errors++;
            $display("FAIL hold got %b need 101001001",
                     {bus.state, bus.lwa, bus.rwa});
        end
        bus.fb = 1; bus.bb = 1;
        while (bus.state !== 3'b000 && n < 20) begin
            step();
            n++;
        end
        checks++;
        if (n !== 5) begin
            errors++;
            $display("FAIL hold_exit got %0d cycles need 5", n);
        end
        step();
        checks++;
        if ({bus.lwa, bus.rwa} !== 6'b010001) begin
            errors++;
            $display("FAIL hold_pass got %b need 010001", {bus.lwa, bus.rwa});
        end
    endtask

    task automatic test_persistent();
        logic [2:0] es;
        logic [5:0] ea;
        int         n = 0;
        bus.rb = 0; step(); step();
        for (int k = 0; k <= 48; k++) begin
            es = (k % 12) < 4 ? 3'b001 : 3'b100;
`ifdef RENEE_SEQ_RETRY_LIMIT_EN
            if (k == 48) es = 3'b110;
`endif
            if (k == 0)                ea = 6'b010001;
            else if (((k - 1) % 12) < 4) ea = 6'b001001;
            else                       ea = 6'b100010;
            checks++;
            if ({bus.state, bus.lwa, bus.rwa} !== {es, ea}) begin
                errors++;
                $display("FAIL persist k=%0d got %b need %b", k,
                         {bus.state, bus.lwa, bus.rwa}, {es, ea});
            end
            if (k < 48) step();
        end
`ifdef RENEE_SEQ_RETRY_LIMIT_EN
        bus.lwa_in = 3'b001; bus.rwa_in = 3'b001;
        step(); step(); step();
        checks++;
        if ({bus.state, bus.lwa, bus.rwa} !== 9'b110001001) begin
            errors++;
            $display("FAIL fault_held got %b need 110001001",
                     {bus.state, bus.lwa, bus.rwa});
        end
        bus.lwa_in = 3'b010; bus.rb = 1;
        step(); step(); step();
        checks++;
        if (bus.state !== 3'b110) begin
            errors++;
            $display("FAIL fault_nostop got %b need 110", bus.state);
        end
        bus.lwa_in = 3'b001;
        step();
        checks++;
        if (bus.state !== 3'b000) begin
            errors++;
            $display("FAIL fault_exit got %b need 000", bus.state);
        end
        bus.lwa_in = 3'b010;
`else
        bus.rb = 1;
`endif
        while (bus.state !== 3'b000 && n < 40) begin
            step();
            n++;
        end
        checks++;
        if (bus.state !== 3'b000) begin
            errors++;
            $display("FAIL persist_exit got %b need 000", bus.state);
        end
        step();
    endtask

    task automatic test_reset_mid();
        bus.fb = 0; step(); bus.fb = 1; step();
        for (int k = 0; k < 6; k++) step();
        checks++;
        if ({bus.state, bus.lwa, bus.rwa} !== 9'b010100100) begin
            errors++;
            $display("FAIL rmid_pre got %b need 010100100",
                     {bus.state, bus.lwa, bus.rwa});
        end
        #2 rst = 1;
        #1;
        checks++;
        if ({bus.busy, bus.state, bus.lwa, bus.rwa} !== 10'b0000001001) begin
            errors++;
            $display("FAIL rmid_async got %b need 0000001001",
                     {bus.busy, bus.state, bus.lwa, bus.rwa});
        end
        step();
        rst = 0;
        step(); step();
        checks++;
        if ({bus.state, bus.lwa, bus.rwa} !== 9'b000010001) begin
            errors++;
            $display("FAIL rmid_after got %b need 000010001",
                     {bus.state, bus.lwa, bus.rwa});
        end
    endtask

    initial begin
        test_reset();
        test_passthrough();
        test_front_hit();
        test_left_hit();
        test_back_hit();
        test_hold();
        test_persistent();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
